// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle DIV/DIVU unit: state encodings and default widths.
package div_unit_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_ON   = 2'b01,
    DIV_END  = 2'b10,
    DIV_ZERO = 2'b11
  } div_state_e;

endpackage : div_unit_pkg

// File: rtl/div_unit.sv
// Radix-2 restoring divider for MIPS DIV/DIVU; one quotient bit per cycle,
// result = {remainder, quotient} with the remainder taking the dividend's sign.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               start,
  input  logic               hassign,
  input  logic               annul,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  div_state_e         state, state_nxt;
  logic [WIDTH-1:0]   rem, rem_nxt;
  logic [WIDTH-1:0]   quo, quo_nxt;
  logic [WIDTH-1:0]   bmag, bmag_nxt;
  logic               sign_a, sign_a_nxt;
  logic               sign_b, sign_b_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic [2*WIDTH-1:0] result_nxt;
  logic [WIDTH:0]     trial;

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= DIV_IDLE;
      rem    <= '0;
      quo    <= '0;
      bmag   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_nxt;
      rem    <= rem_nxt;
      quo    <= quo_nxt;
      bmag   <= bmag_nxt;
      sign_a <= sign_a_nxt;
      sign_b <= sign_b_nxt;
      cnt    <= cnt_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      result <= result_nxt;
    end
  end

  // Next-state, iteration step and sign fix-up
  always_comb begin
    state_nxt  = state;
    rem_nxt    = rem;
    quo_nxt    = quo;
    bmag_nxt   = bmag;
    sign_a_nxt = sign_a;
    sign_b_nxt = sign_b;
    cnt_nxt    = cnt;
    done_nxt   = 1'b0;
    result_nxt = result;
    trial      = {rem, quo[WIDTH-1]} - {1'b0, bmag};

    if (annul) begin
      state_nxt = DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            sign_a_nxt = hassign & a[WIDTH-1];
            sign_b_nxt = hassign & b[WIDTH-1];
            quo_nxt    = sign_a_nxt ? neg(a) : a;
            bmag_nxt   = sign_b_nxt ? neg(b) : b;
            rem_nxt    = '0;
            cnt_nxt    = '0;
            state_nxt  = (b == '0) ? DIV_ZERO : DIV_ON;
          end
        end
        DIV_ON: begin
          // Restore by keeping the shifted remainder when the trial goes negative
          if (!trial[WIDTH]) begin
            rem_nxt = trial[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem_nxt = {rem[WIDTH-2:0], quo[WIDTH-1]};
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
          end
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state_nxt = DIV_END;
          end
        end
        DIV_END: begin
          done_nxt   = 1'b1;
          result_nxt = {(sign_a ? neg(rem) : rem),
                        ((sign_a ^ sign_b) ? neg(quo) : quo)};
          state_nxt  = DIV_IDLE;
        end
        DIV_ZERO: begin
          done_nxt   = 1'b1;
          result_nxt = '0;
          state_nxt  = DIV_IDLE;
        end
        default: state_nxt = DIV_IDLE;
      endcase
    end

    // busy stays up through the done cycle so the stall covers the HI/LO write
    busy_nxt = (state_nxt != DIV_IDLE) | done_nxt;
  end

endmodule : div_unit
